// File: rtl/psum_acc_pkg.sv
// Shared types and constants for the psum read-modify-write accumulator.
// Word and address widths are fixed here; the top-level parameters default to them.
package psum_acc_pkg;

  localparam int PSUM_DATA_W = 16;
  localparam int PSUM_ADDR_W = 10;

  localparam logic [PSUM_DATA_W-1:0] PSUM_SAT_MAX = {1'b0, {(PSUM_DATA_W-1){1'b1}}};
  localparam logic [PSUM_DATA_W-1:0] PSUM_SAT_MIN = {1'b1, {(PSUM_DATA_W-1){1'b0}}};

  typedef struct packed {
    logic                   valid;
    logic                   first;
    logic [PSUM_ADDR_W-1:0] addr;
    logic [PSUM_DATA_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/psum_sat_adder.sv
// Combinational signed psum adder; saturates when PSUM_SAT_EN is defined,
// otherwise wraps in two's complement.
module psum_sat_adder
  import psum_acc_pkg::*;
(
  input  logic [PSUM_DATA_W-1:0] a,
  input  logic [PSUM_DATA_W-1:0] b,
  output logic [PSUM_DATA_W-1:0] sum
);

  logic [PSUM_DATA_W-1:0] raw;

  assign raw = a + b;

`ifdef PSUM_SAT_EN
  logic ovf_pos;
  logic ovf_neg;

  // Overflow only when both operands share a sign the result does not.
  assign ovf_pos = !a[PSUM_DATA_W-1] && !b[PSUM_DATA_W-1] &&  raw[PSUM_DATA_W-1];
  assign ovf_neg =  a[PSUM_DATA_W-1] &&  b[PSUM_DATA_W-1] && !raw[PSUM_DATA_W-1];

  always_comb begin
    sum = raw;
    if (ovf_pos) begin
      sum = PSUM_SAT_MAX;
    end else if (ovf_neg) begin
      sum = PSUM_SAT_MIN;
    end
  end
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/glb_psum_accumulator.sv
// Psum GLB read-modify-write front end: read at accept, add in S2, write from S3.
// S3/S4 forwarding covers same-address hazards. Build option: PSUM_SAT_EN.
module glb_psum_accumulator
  import psum_acc_pkg::*;
#(
  parameter int DATA_BITWIDTH = PSUM_DATA_W,
  parameter int ADDR_BITWIDTH = PSUM_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_BITWIDTH-1:0] in_addr,
  input  logic [DATA_BITWIDTH-1:0] in_data,
  input  logic                     in_first,
  output logic                     read_req_psum,
  output logic [ADDR_BITWIDTH-1:0] r_addr_psum,
  input  logic [DATA_BITWIDTH-1:0] r_data_psum,
  output logic                     write_en_psum,
  output logic [ADDR_BITWIDTH-1:0] w_addr_psum,
  output logic [DATA_BITWIDTH-1:0] w_data_psum,
  output logic                     busy,
  output logic [15:0]              acc_count
);

  stage_t s2_reg;
  stage_t s3_reg;
  stage_t s4_reg;
  stage_t s3_next;

  logic                     accept;
  logic [DATA_BITWIDTH-1:0] operand;
  logic [DATA_BITWIDTH-1:0] sum;
  logic [15:0]              acc_count_reg;

  assign in_ready      = !reset;
  assign accept        = in_valid && in_ready;
  assign read_req_psum = accept && !in_first;
  assign r_addr_psum   = reset ? '0 : in_addr;

  // GLB reads return pre-write data, so both S3 (not yet written) and
  // S4 (written on the same edge the read was sampled) must be forwarded.
  always_comb begin
    operand = r_data_psum;
    if (s2_reg.first) begin
      operand = '0;
    end else if (s3_reg.valid && (s3_reg.addr == s2_reg.addr)) begin
      operand = s3_reg.data;
    end else if (s4_reg.valid && (s4_reg.addr == s2_reg.addr)) begin
      operand = s4_reg.data;
    end
  end

  psum_sat_adder u_adder (
    .a   (operand),
    .b   (s2_reg.data),
    .sum (sum)
  );

  always_comb begin
    s3_next      = s2_reg;
    s3_next.data = sum;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_reg        <= '0;
      s3_reg        <= '0;
      s4_reg        <= '0;
      acc_count_reg <= '0;
    end else begin
      s2_reg.valid <= accept;
      s2_reg.first <= in_first;
      s2_reg.addr  <= in_addr;
      s2_reg.data  <= in_data;
      s3_reg       <= s3_next;
      s4_reg       <= s3_reg;
      if (s3_reg.valid) begin
        acc_count_reg <= acc_count_reg + 16'd1;
      end
    end
  end

  assign write_en_psum = s3_reg.valid;
  assign w_addr_psum   = s3_reg.addr;
  assign w_data_psum   = s3_reg.data;
  assign busy          = s2_reg.valid || s3_reg.valid;
  assign acc_count     = acc_count_reg;

endmodule
